// File: rtl/store_unit.sv
// RV32I store sequencer: alignment check, lane shifting and a req/gnt/ack write
// handshake with an optional timeout. One store in flight; all outputs registered.
package store_unit_pkg;
    typedef enum logic [1:0] {
        sk_sb      = 2'd0,
        sk_sh      = 2'd1,
        sk_sw      = 2'd2,
        sk_invalid = 2'd3
    } store_kind_t;
endpackage

module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  store_kind_t kind,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err_misaligned,
    output logic        err_bus,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_ack,
    input  logic        mem_err
);

    localparam bit          TimeoutEn  = (TIMEOUT_CYCLES > 0);
    localparam int unsigned CntW       = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CntLastInt = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(CntLastInt);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_mis_q, err_mis_d;
    logic              err_bus_q, err_bus_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    logic [3:0]        be_new;
    logic [31:0]       wd_new;
    logic              bad_new;
    logic              timeout_hit;

    // Lane steering for the incoming store; invalid kinds fall through as faults.
    always_comb begin
        be_new  = 4'b0000;
        wd_new  = wdata;
        bad_new = 1'b1;
        case (kind)
            sk_sb: begin
                be_new  = 4'b0001 << addr[1:0];
                wd_new  = {4{wdata[7:0]}};
                bad_new = 1'b0;
            end
            sk_sh: begin
                be_new  = addr[1] ? 4'b1100 : 4'b0011;
                wd_new  = {2{wdata[15:0]}};
                bad_new = addr[0];
            end
            sk_sw: begin
                be_new  = 4'b1111;
                wd_new  = wdata;
                bad_new = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_mis_d   = 1'b0;
        err_bus_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        // Advancing events (gnt/ack) are tested first so they win over the timeout.
        case (state_q)
            StIdle: begin
                if (start) begin
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wdata_d = wd_new;
                    mem_be_d    = be_new;
                    cnt_d       = '0;
                    if (bad_new) begin
                        state_d   = StDone;
                        err_mis_d = 1'b1;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d   = StReq;
                        mem_req_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (TimeoutEn) cnt_d = cnt_q + CntW'(1);
                if (mem_gnt) begin
                    state_d   = StWait;
                    mem_req_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    err_bus_d = 1'b1;
                    mem_req_d = 1'b0;
                end
            end
            StWait: begin
                if (TimeoutEn) cnt_d = cnt_q + CntW'(1);
                if (mem_ack) begin
                    state_d   = StDone;
                    err_bus_d = mem_err;
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    err_bus_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_mis_q   <= 1'b0;
            err_bus_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_mis_q   <= err_mis_d;
            err_bus_q   <= err_bus_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_misaligned = err_mis_q;
    assign err_bus        = err_bus_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: expected completions and bus writes are queued at
// issue time and popped by negedge monitors when the DUT reports them.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    store_kind_t kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err_misaligned;
    logic        err_bus;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_ack;
    logic        mem_err;

    typedef struct {
        int   cyc;
        logic mis;
        logic bus;
    } done_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } bus_t;

    done_t exp_q[$];
    bus_t  bus_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    store_unit #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .kind          (kind),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .err_misaligned(err_misaligned),
        .err_bus       (err_bus),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_gnt       (mem_gnt),
        .mem_ack       (mem_ack),
        .mem_err       (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_t b;
        b.a = a;
        b.d = d;
        b.be = be;
        bus_q.push_back(b);
    endtask

    // Drive start for one cycle; the current cycle is cycle 0 of the store.
    task automatic issue(input store_kind_t k, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic mis, input logic eb);
        done_t e;
        e.cyc = cyc + lat;
        e.mis = mis;
        e.bus = eb;
        exp_q.push_back(e);
        kind  = k;
        addr  = a;
        wdata = d;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in cycle 1: grant after gnt_dly idle cycles, ack after ack_dly more.
    task automatic run_bus(input int gnt_dly, input int ack_dly, input logic err);
        repeat (gnt_dly) step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        repeat (ack_dly) step();
        mem_ack = 1'b1;
        mem_err = err;
        step();
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_errs"}, {err_misaligned, err_bus}, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_be"}, mem_be, 0);
    endtask

    always @(negedge clk) begin
        done_t e;
        bus_t  b;
        if (done) begin
            chk("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("err_misaligned", err_misaligned, e.mis);
                chk("err_bus", err_bus, e.bus);
            end
        end else begin
            chk("flags_without_done", {err_misaligned, err_bus}, 0);
        end
        if (mem_req && mem_gnt) begin
            chk("grant_expected", 32'(bus_q.size() != 0), 1);
            if (bus_q.size() != 0) begin
                b = bus_q.pop_front();
                chk("mem_addr", mem_addr, b.a);
                chk("mem_wdata", mem_wdata, b.d);
                chk("mem_be", mem_be, b.be);
            end
        end
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        kind    = sk_sb;
        addr    = '0;
        wdata   = '0;
        mem_gnt = 1'b0;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        step();
        step();
        chk_reset("reset");
        rst = 1'b1;
        step();

        // SB at 0x1003, immediate gnt/ack
        expect_bus(32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
        issue(sk_sb, 32'h0000_1003, 32'hAABB_CCDD, 3, 1'b0, 1'b0);
        chk("sb_req_c1", mem_req, 1);
        chk("sb_busy_c1", busy, 1);
        run_bus(0, 0, 1'b0);
        wait_idle("sb_complete");
        chk("sb_busy_after", busy, 0);

        // SH misaligned, then back-to-back SH at cycle 2
        issue(sk_sh, 32'h0000_2001, 32'h0000_1234, 1, 1'b1, 1'b0);
        chk("shmis_req_c1", mem_req, 0);
        chk("shmis_busy_c1", busy, 1);
        step();
        chk("shmis_req_c2", mem_req, 0);
        chk("shmis_busy_c2", busy, 0);
        expect_bus(32'h0000_2000, 32'h1234_1234, 4'b1100);
        issue(sk_sh, 32'h0000_2002, 32'h0000_1234, 3, 1'b0, 1'b0);
        run_bus(0, 0, 1'b0);
        wait_idle("sh_complete");

        // SW with gnt delayed 4 and ack delayed 2 more; start pulses while busy
        expect_bus(32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
        issue(sk_sw, 32'h0000_3000, 32'hCAFE_F00D, 9, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            chk("sw_busy", busy, 1);
            chk("sw_req", mem_req, 32'(c <= 5));
            if (c <= 5) chk("sw_addr_stable", mem_addr, 32'h0000_3000);
            mem_gnt = (c == 5);
            mem_ack = (c == 8);
            start   = c[0];
            kind    = sk_sb;
            addr    = 32'h0000_0044;
            step();
        end
        start   = 1'b0;
        mem_gnt = 1'b0;
        mem_ack = 1'b0;
        chk("sw_idle_c10", busy, 0);
        step();
        chk("sw_no_requeue", busy, 0);
        wait_idle("sw_complete");

        // Timeout: gnt never arrives
        issue(sk_sw, 32'h0000_4000, 32'h1111_2222, 9, 1'b0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            chk("to_req_held", mem_req, 1);
            step();
        end
        chk("to_req_dropped", mem_req, 0);
        wait_idle("to_complete");

        // Ack on the last counted WAIT cycle wins over the timeout
        expect_bus(32'h0000_4100, 32'h3333_4444, 4'b1111);
        issue(sk_sw, 32'h0000_4100, 32'h3333_4444, 9, 1'b0, 1'b0);
        run_bus(0, 6, 1'b0);
        wait_idle("late_ack_complete");

        // Bus error on ack
        expect_bus(32'h0000_5004, 32'h5555_6666, 4'b1111);
        issue(sk_sw, 32'h0000_5004, 32'h5555_6666, 3, 1'b0, 1'b1);
        run_bus(0, 0, 1'b1);
        wait_idle("buserr_complete");

        // Invalid kind: fault with no bus activity
        issue(sk_invalid, 32'h0000_6000, 32'h7777_8888, 1, 1'b1, 1'b0);
        chk("inv_req_c1", mem_req, 0);
        step();
        chk("inv_req_c2", mem_req, 0);
        wait_idle("inv_complete");

        // Reset while in WAIT: no done, then a normal store
        expect_bus(32'h0000_7000, 32'h9999_AAAA, 4'b1111);
        issue(sk_sw, 32'h0000_7000, 32'h9999_AAAA, 3, 1'b0, 1'b0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_reset("midreset");
        repeat (4) step();
        expect_bus(32'h0000_8000, 32'h5A5A_5A5A, 4'b0010);
        issue(sk_sb, 32'h0000_8001, 32'h0000_005A, 3, 1'b0, 1'b0);
        run_bus(0, 0, 1'b0);
        wait_idle("post_reset_complete");
        chk("bus_queue_drained", bus_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Sequencing controller for RV32I stores, sitting between decode/execute and the data-memory port. Accepts one store (kind from `decode_store`, address, register data) and checks alignment. Drives a lane-shifted, byte-enabled write through a request/grant/acknowledge bus handshake, then reports completion or error to the pipeline. One store in flight at a time; `busy` stalls the issuing stage.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+WAIT before aborting with a bus error; 0 disables the timeout.

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (`rst`=0 at a rising edge resets)
- `start`  in  1  store request; sampled only in IDLE
- `kind`  in  `store_kind_t` (`instr_type`)  `sk_sb`/`sk_sh`/`sk_sw`/`sk_invalid`
- `addr`  in  32  byte address
- `wdata`  in  32  rs2 value; low byte/half/word used per `kind`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err_misaligned`  out  1  valid with `done`: alignment fault or `sk_invalid`
- `err_bus`  out  1  valid with `done`: `mem_err` or timeout
- `mem_req`  out  1  write request
- `mem_addr`  out  32  word address `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated data
- `mem_be`  out  4  byte enables
- `mem_gnt`  in  1  request accepted
- `mem_ack`  in  1  write completed
- `mem_err`  in  1  bus error; meaningful only with `mem_ack`

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE: on `start`, capture `kind`, `addr`, `wdata` and compute lanes:
  - `sk_sb`: `mem_be` = 1<<addr[1:0]; `mem_wdata` = {4{wdata[7:0]}}; never misaligned.
  - `sk_sh`: misaligned if addr[0]; `mem_be` = addr[1] ? 4'b1100 : 4'b0011; `mem_wdata` = {2{wdata[15:0]}}.
  - `sk_sw`: misaligned if addr[1:0]≠0; `mem_be` = 4'b1111; `mem_wdata` = wdata.
  - `sk_sinvalid` or misaligned: go to DONE with `err_misaligned`=1. Never assert `mem_req`.
  - Otherwise go to REQ with `mem_req`=1. Clear the timeout counter.
- REQ: hold `mem_req`, `mem_addr`, `mem_wdata`, `mem_be` stable. On `mem_gnt`, drop `mem_req` and go to WAIT. `mem_ack` is ignored in REQ.
- WAIT: on `mem_ack`, go to DONE; set `err_bus` = `mem_err`.
- Timeout (`TIMEOUT_CYCLES`>0): counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle in REQ/WAIT.
  - If counter == TIMEOUT_CYCLES-1 and no advancing event (gnt in REQ, ack in WAIT) that cycle: go to DONE with `err_bus`=1 and `mem_req` dropped.
  - An advancing event in the same cycle wins over the timeout.
- DONE: `done`=1 for exactly one cycle with the error flags, then return to IDLE. Error flags are 0 whenever `done`=0.
- `start` outside IDLE is ignored; it is not queued.
- Reset values: state IDLE; `busy`, `done`, `err_misaligned`, `err_bus`, `mem_req`=0; `mem_addr`, `mem_wdata`=0; `mem_be`=4'b0000; counter 0.
- Reset mid-operation: next edge forces IDLE, drops `mem_req`, emits no `done`. Any outstanding bus transaction is abandoned.

## Timing
- Cycle 0 `start` in IDLE → cycle 1 `mem_req`=1, `busy`=1.
- `mem_gnt` at cycle 1 → cycle 2 WAIT, `mem_req`=0.
- `mem_ack` at cycle 2 → cycle 3 `done`=1 → cycle 4 IDLE, `busy`=0. Minimum start-to-done latency is 3 cycles.
- Misaligned/invalid: `done`+`err_misaligned` at cycle 1. Back-to-back `start` accepted at cycle 2.
- Each extra cycle without `mem_gnt`/`mem_ack` adds one cycle. Worst case `done` at cycle TIMEOUT_CYCLES+1.
- A new `start` is first accepted in the cycle after `done`, which is when the state is IDLE.

## Test plan
- SB, addr 0x1003, wdata 0xAABBCCDD; gnt and ack immediate → `mem_addr`=0x1000, `mem_be`=4'b1000, `mem_wdata`=0xDDDDDDDD; `done` at cycle 3 with no errors.
- SH at 0x2002, wdata 0x1234 → `mem_be`=4'b1100, `mem_wdata`=0x12341234. SH at 0x2001 → `done`+`err_misaligned` at cycle 1, `mem_req` never high.
- SW at 0x3000; gnt delayed 4 cycles, ack delayed 2 more → `mem_req` held stable for 5 cycles; `done` at cycle 9; `busy` high cycles 1–9; `start` pulses during busy are ignored.
- `TIMEOUT_CYCLES`=8, gnt never asserted → `mem_req` high cycles 1–8; `done`+`err_bus` at cycle 9. Repeat with `mem_ack` arriving on the final counted WAIT cycle → success with no error.
- SW with `mem_ack`&`mem_err` → `done`+`err_bus`=1. `kind`=`sk_invalid` → `err_misaligned`=1, no bus activity.
- `rst`=0 while in WAIT → next cycle all outputs at reset values; no `done`; the next `start` completes normally.
